// File: rtl/asym_fifo_narrow_to_wide_if.sv
// rtl/asym_fifo_narrow_to_wide_if.sv - handshake bundle for the narrow-to-wide FIFO
interface asym_fifo_narrow_to_wide_if #(
    parameter int WIDTHN     = 4,
    parameter int WIDTHW     = 16,
    parameter int ADDRWIDTHW = 6
);
    localparam int LANEW = $clog2(WIDTHW / WIDTHN);

    logic                  flush;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [WIDTHN-1:0]     wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [WIDTHW-1:0]     rd_data;
    logic [ADDRWIDTHW:0]   level;
    logic [LANEW-1:0]      lane;

    modport master (
        output flush, wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, level, lane
    );

    modport slave (
        input  flush, wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, level, lane
    );
endinterface

// File: rtl/asym_fifo_narrow_to_wide.sv
// rtl/asym_fifo_narrow_to_wide.sv - narrow-write / wide-read FIFO, lane packing order set by ASYM_FIFO_MSB_FIRST_EN
module asym_fifo_narrow_to_wide #(
    parameter int WIDTHN     = 4,
    parameter int WIDTHW     = 16,
    parameter int DEPTHW     = 64,
    parameter int ADDRWIDTHW = 6
) (
    input logic clk,
    input logic reset_n,
    asym_fifo_narrow_to_wide_if.slave bus
);
    localparam int RATIO  = WIDTHW / WIDTHN;
    localparam int LANEW  = $clog2(RATIO);
    localparam int LEVELW = ADDRWIDTHW + 1;

    logic [WIDTHW-1:0]     mem [DEPTHW];
    logic [ADDRWIDTHW-1:0] wrPtr;
    logic [ADDRWIDTHW-1:0] rdPtr;
    logic [LEVELW-1:0]     level;
    logic [LANEW-1:0]      lane;
    logic [WIDTHW-1:0]     packReg;
    logic [WIDTHW-1:0]     rdData;
    logic                  rdValid;
    logic                  armed;

    logic                  wrReady;
    logic                  wrAccept;
    logic                  wrComplete;
    logic                  rdPop;
    logic                  ramRead;
    logic [LEVELW-1:0]     ramCount;
    logic [LANEW-1:0]      laneSel;
    logic [WIDTHW-1:0]     packNext;

    // The completing lane is only refused when RAM and output register are both full.
    assign wrReady    = armed && ((level != LEVELW'(DEPTHW + 1)) || (lane != LANEW'(RATIO - 1)));
    assign wrAccept   = bus.wr_valid && wrReady;
    assign wrComplete = wrAccept && (lane == LANEW'(RATIO - 1));
    assign rdPop      = rdValid && bus.rd_ready;
    assign ramCount   = level - LEVELW'(rdValid);
    assign ramRead    = (ramCount != '0) && (!rdValid || bus.rd_ready);

`ifdef ASYM_FIFO_MSB_FIRST_EN
    assign laneSel = ~lane;
`else
    assign laneSel = lane;
`endif

    always_comb begin
        packNext = packReg;
        packNext[laneSel*WIDTHN +: WIDTHN] = bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (wrComplete && !bus.flush) begin
            mem[wrPtr] <= packNext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            level   <= '0;
            lane    <= '0;
            packReg <= '0;
            rdData  <= '0;
            rdValid <= 1'b0;
            armed   <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (bus.flush) begin
                // rdData deliberately keeps its last value.
                wrPtr   <= '0;
                rdPtr   <= '0;
                level   <= '0;
                lane    <= '0;
                packReg <= '0;
                rdValid <= 1'b0;
            end else begin
                if (wrAccept) begin
                    lane    <= lane + LANEW'(1);
                    packReg <= packNext;
                    if (wrComplete) begin
                        wrPtr <= wrPtr + ADDRWIDTHW'(1);
                    end
                end
                if (ramRead) begin
                    rdData  <= mem[rdPtr];
                    rdPtr   <= rdPtr + ADDRWIDTHW'(1);
                    rdValid <= 1'b1;
                end else if (rdPop) begin
                    rdValid <= 1'b0;
                end
                level <= level + LEVELW'(wrComplete) - LEVELW'(rdPop);
            end
        end
    end

    assign bus.wr_ready = wrReady;
    assign bus.rd_valid = rdValid;
    assign bus.rd_data  = rdData;
    assign bus.level    = level;
    assign bus.lane     = lane;
endmodule

// File: tb/tb_asym_fifo_narrow_to_wide.sv
// tb/tb_asym_fifo_narrow_to_wide.sv - directed bench for asym_fifo_narrow_to_wide
module tb_asym_fifo_narrow_to_wide;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    asym_fifo_narrow_to_wide_if #(.WIDTHN(4), .WIDTHW(16), .ADDRWIDTHW(6)) bus ();

    asym_fifo_narrow_to_wide #(.WIDTHN(4), .WIDTHW(16), .DEPTHW(64), .ADDRWIDTHW(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wrNib(input logic [3:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    function automatic logic [15:0] expWord(input int w);
        logic [15:0] r;
        for (int k = 0; k < 4; k++) begin
`ifdef ASYM_FIFO_MSB_FIRST_EN
            r[(3-k)*4 +: 4] = 4'(4*w + k);
`else
            r[k*4 +: 4] = 4'(4*w + k);
`endif
        end
        return r;
    endfunction

    task automatic drain(input int firstW, input int n);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            int budget = 0;
            while (!bus.rd_valid && budget < 10) begin
                tick();
                budget++;
            end
            chk("drain_word", 32'(bus.rd_data), 32'(expWord(firstW + i)));
            tick();
        end
        bus.rd_ready = 1'b0;
    endtask

    initial begin
        int nib;
        int got;
        int cyc;
        int maxLevel;
        logic accept;
        bus.flush = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data = '0;
        bus.rd_ready = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_ready", 32'(bus.wr_ready), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_lane", 32'(bus.lane), 0);
        reset_n = 1'b1;
        chk("rel_wr_ready_pre", 32'(bus.wr_ready), 0);
        tick();
        chk("rel_wr_ready_post", 32'(bus.wr_ready), 1);

        // basic packing and latency
        wrNib(4'h1); wrNib(4'h2); wrNib(4'h3); wrNib(4'h4);
        chk("t1_level", 32'(bus.level), 1);
        chk("t1_rd_valid_early", 32'(bus.rd_valid), 0);
        tick();
        chk("t1_rd_valid", 32'(bus.rd_valid), 1);
`ifdef ASYM_FIFO_MSB_FIRST_EN
        chk("t1_rd_data", 32'(bus.rd_data), 32'h1234);
`else
        chk("t1_rd_data", 32'(bus.rd_data), 32'h4321);
`endif
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("t1_pop_valid", 32'(bus.rd_valid), 0);
        chk("t1_pop_level", 32'(bus.level), 0);

        // fill to capacity and stall the completing lane
        for (int i = 0; i < 260; i++) wrNib(4'(i));
        chk("t2_level_full", 32'(bus.level), 65);
        chk("t2_lane0", 32'(bus.lane), 0);
        chk("t2_ready_lane0", 32'(bus.wr_ready), 1);
        for (int i = 260; i < 263; i++) wrNib(4'(i));
        chk("t2_lane3", 32'(bus.lane), 3);
        chk("t2_ready_stall", 32'(bus.wr_ready), 0);
        bus.wr_valid = 1'b1;
        bus.wr_data = 4'h7;
        tick();
        chk("t2_lane_held", 32'(bus.lane), 3);
        chk("t2_level_held", 32'(bus.level), 65);
        chk("t2_head_stable", 32'(bus.rd_data), 32'(expWord(0)));
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("t2_ready_back", 32'(bus.wr_ready), 1);
        chk("t2_level_after_pop", 32'(bus.level), 64);
        chk("t2_next_head", 32'(bus.rd_data), 32'(expWord(1)));
        tick();
        bus.wr_valid = 1'b0;
        chk("t2_level_refill", 32'(bus.level), 65);
        chk("t2_lane_wrap", 32'(bus.lane), 0);
        drain(1, 65);
        chk("t2_level_empty", 32'(bus.level), 0);

        // streaming
        nib = 0; got = 0; cyc = 0; maxLevel = 0;
        bus.rd_ready = 1'b1;
        while (got < 100 && cyc < 1000) begin
            bus.wr_valid = (nib < 400);
            bus.wr_data = 4'(nib);
            accept = bus.wr_valid && bus.wr_ready;
            if (bus.rd_valid) begin
                chk("t3_word", 32'(bus.rd_data), 32'(expWord(got)));
                got++;
            end
            tick();
            if (accept) nib++;
            if (int'(bus.level) > maxLevel) maxLevel = int'(bus.level);
            cyc++;
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        chk("t3_words", 32'(got), 100);
        chk("t3_nibbles", 32'(nib), 400);
        chk("t3_level_bound", 32'(maxLevel <= 2), 1);
        tick();
        chk("t3_level_end", 32'(bus.level), 0);

        // flush with partial word pending
        for (int i = 0; i < 22; i++) wrNib(4'(i));
        chk("t4_level", 32'(bus.level), 5);
        chk("t4_lane", 32'(bus.lane), 2);
        chk("t4_head", 32'(bus.rd_data), 32'(expWord(0)));
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t4_flush_level", 32'(bus.level), 0);
        chk("t4_flush_lane", 32'(bus.lane), 0);
        chk("t4_flush_valid", 32'(bus.rd_valid), 0);
        chk("t4_flush_data_hold", 32'(bus.rd_data), 32'(expWord(0)));
        wrNib(4'h9); wrNib(4'h8); wrNib(4'h7); wrNib(4'h6);
        tick();
        chk("t4_post_valid", 32'(bus.rd_valid), 1);
`ifdef ASYM_FIFO_MSB_FIRST_EN
        chk("t4_post_data", 32'(bus.rd_data), 32'h9876);
`else
        chk("t4_post_data", 32'(bus.rd_data), 32'h6789);
`endif
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        chk("t4_post_level", 32'(bus.level), 0);

        // asynchronous reset mid-word
        wrNib(4'h5);
        chk("t5_lane1", 32'(bus.lane), 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t5_async_lane", 32'(bus.lane), 0);
        chk("t5_async_level", 32'(bus.level), 0);
        chk("t5_async_ready", 32'(bus.wr_ready), 0);
        chk("t5_async_valid", 32'(bus.rd_valid), 0);
        chk("t5_async_data", 32'(bus.rd_data), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("t5_ready_back", 32'(bus.wr_ready), 1);
        tick();
        tick();
        chk("t5_no_word_valid", 32'(bus.rd_valid), 0);
        chk("t5_no_word_level", 32'(bus.level), 0);
        wrNib(4'hA); wrNib(4'hB); wrNib(4'hC); wrNib(4'hD);
        tick();
        chk("t5_fresh_valid", 32'(bus.rd_valid), 1);
`ifdef ASYM_FIFO_MSB_FIRST_EN
        chk("t5_fresh_data", 32'(bus.rd_data), 32'hABCD);
`else
        chk("t5_fresh_data", 32'(bus.rd_data), 32'hDCBA);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
